// File: rtl/mac_pkg.sv
// Shared types and instruction encodings for the MAC array sequencer.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KLOAD  = 3'd1,
        KFLUSH = 3'd2,
        EXEC   = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] INST_NOP   = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

endpackage

// File: rtl/seq_cnt.sv
// Clear/enable up-counter with an equality compare against a terminal value.
module seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc,
    output logic [W-1:0] cnt,
    output logic         at_tc
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt   = cnt_reg;
    assign at_tc = (cnt_reg == tc);

endmodule

// File: rtl/mac_array_seq_ctrl.sv
// Tile sequencer: kernel load, kernel flush, activation execute, output drain.
// Issues L0 reads, drives mac_array.inst_w one cycle later and counts output vectors.
module mac_array_seq_ctrl
    import mac_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [len_bw-1:0] num_x,
    input  logic              l0_empty,
    output logic              l0_rd,
    input  logic              ofifo_afull,
    input  logic [col-1:0]    array_valid,
    output logic [1:0]        inst_w,
    output logic              busy,
    output logic              done,
    output logic [len_bw-1:0] out_cnt
);

    localparam int KW = $clog2(col + 1);
    localparam int FW = $clog2(row + 1);

    state_t            state_reg, state_next;
    logic [len_bw-1:0] num_x_reg;
    logic [1:0]        inst_w_reg;

    logic issue_k, issue_x, f_en, start_acc, out_en;
    logic k_last, f_last, x_last, out_full;

    logic [KW-1:0]     k_cnt, k_tc;
    logic [FW-1:0]     f_cnt, f_tc;
    logic [len_bw-1:0] x_cnt, x_tc;
    logic              cnt_unused, valid_unused;

    // Terminal values are one below the length so the transition lands on the last issue.
    assign k_tc = KW'(col - 1);
    assign f_tc = FW'(row - 1);
    assign x_tc = num_x_reg - len_bw'(1);

    assign start_acc = (state_reg == IDLE) && start;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign out_en    = busy && array_valid[col-1] && !out_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            num_x_reg  <= '0;
            inst_w_reg <= INST_NOP;
        end else begin
            state_reg <= state_next;
            if (start_acc) begin
                num_x_reg <= num_x;
            end
            // Follows l0_rd by one cycle so it lines up with L0 read data.
            if (issue_k) begin
                inst_w_reg <= INST_KLOAD;
            end else if (issue_x) begin
                inst_w_reg <= INST_EXEC;
            end else begin
                inst_w_reg <= INST_NOP;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        issue_k    = 1'b0;
        issue_x    = 1'b0;
        f_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = KLOAD;
            end
            KLOAD: begin
                issue_k = !l0_empty;
                if (issue_k && k_last) state_next = KFLUSH;
            end
            KFLUSH: begin
                f_en = 1'b1;
                if (f_last) state_next = (num_x_reg != '0) ? EXEC : DONE;
            end
            EXEC: begin
                issue_x = !l0_empty && !ofifo_afull;
                if (issue_x && x_last) state_next = DRAIN;
            end
            DRAIN: begin
                if (out_full) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign l0_rd  = issue_k || issue_x;
    assign inst_w = inst_w_reg;

    seq_cnt #(.W(KW)) u_k_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .en(issue_k),
        .tc(k_tc), .cnt(k_cnt), .at_tc(k_last)
    );

    seq_cnt #(.W(FW)) u_f_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .en(f_en),
        .tc(f_tc), .cnt(f_cnt), .at_tc(f_last)
    );

    seq_cnt #(.W(len_bw)) u_x_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .en(issue_x),
        .tc(x_tc), .cnt(x_cnt), .at_tc(x_last)
    );

    // Saturates at num_x: the terminal compare also gates further increments.
    seq_cnt #(.W(len_bw)) u_out_cnt (
        .clk(clk), .reset(reset), .clr(start_acc), .en(out_en),
        .tc(num_x_reg), .cnt(out_cnt), .at_tc(out_full)
    );

    assign cnt_unused   = ^{k_cnt, f_cnt, x_cnt};
    assign valid_unused = ^array_valid[col-2:0];

endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
// Directed bench for the tile sequencer: traces each tile cycle by cycle and checks it.
module tb_mac_array_seq_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int LBW = 8;
    localparam int MAXT = 300;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [LBW-1:0] num_x = '0;
    logic           l0_empty = 1'b0;
    logic           l0_rd;
    logic           ofifo_afull = 1'b0;
    logic [COL-1:0] array_valid = '0;
    logic [1:0]     inst_w;
    logic           busy;
    logic           done;
    logic [LBW-1:0] out_cnt;

    int checks = 0;
    int failures = 0;

    logic       rd_tr [0:MAXT-1];
    logic [1:0] iw_tr [0:MAXT-1];
    logic       dn_tr [0:MAXT-1];
    logic       bz_tr [0:MAXT-1];
    int done_t, n_done, n_k, n_x, rd_af, last_t;

    mac_array_seq_ctrl #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_x(num_x),
        .l0_empty(l0_empty), .l0_rd(l0_rd), .ofifo_afull(ofifo_afull),
        .array_valid(array_valid), .inst_w(inst_w), .busy(busy),
        .done(done), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a tile at the current cycle, then drives windowed stimulus indexed by
    // cycle t after the start edge (t=0 is the first KLOAD cycle) and records outputs.
    task automatic run_tile(input int nx, input int e_a, input int e_b,
                            input int a_a, input int a_b, input int v_a, input int v_b,
                            input int st_t, input int rst_t);
        bit finished = 0;
        reset = 0; start = 1; num_x = LBW'(nx);
        l0_empty = 0; ofifo_afull = 0; array_valid = '0;
        @(posedge clk); #1;
        start = 0;
        done_t = -1; n_done = 0; n_k = 0; n_x = 0; rd_af = 0; last_t = 0;
        for (int t = 0; t < MAXT; t++) begin
            l0_empty    = (t >= e_a) && (t <= e_b);
            ofifo_afull = (t >= a_a) && (t <= a_b);
            array_valid = ((t >= v_a) && (t <= v_b)) ? COL'(1) << (COL - 1) : '0;
            start       = (t == st_t);
            if (t == st_t) num_x = LBW'(7);
            reset       = (t == rst_t);
            #2;
            rd_tr[t] = l0_rd; iw_tr[t] = inst_w; dn_tr[t] = done; bz_tr[t] = busy;
            if (done) begin
                n_done++;
                if (done_t < 0) done_t = t;
            end
            if (inst_w == 2'b01) n_k++;
            if (inst_w == 2'b10) n_x++;
            if (l0_rd && ofifo_afull) rd_af++;
            last_t = t;
            @(posedge clk); #1;
            if ((done_t >= 0 && t >= done_t + 2) || (rst_t >= 0 && t >= rst_t + 4)) begin
                finished = 1;
                break;
            end
        end
        start = 0; reset = 0; l0_empty = 0; ofifo_afull = 0; array_valid = '0;
        if (!finished) check("tile_timeout", 0, 1);
    endtask

    initial begin
        int first_k, last_k, bubbles;

        // 1: reset held with start asserted
        reset = 1; start = 1; num_x = LBW'(4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_busy", busy, 0);
            check("rst_inst_w", inst_w, 0);
            check("rst_l0_rd", l0_rd, 0);
            check("rst_done", done, 0);
            check("rst_out_cnt", out_cnt, 0);
        end
        reset = 0; start = 0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // 2: num_x=4, no stalls, valids in DRAIN, start pulsed in the DONE cycle
        run_tile(4, -1, -1, -1, -1, 20, 23, 25, -1);
        for (int t = 0; t <= 27 && t <= last_t; t++) begin
            int e_rd, e_iw;
            e_rd = (t < 8 || (t >= 16 && t < 20)) ? 1 : 0;
            e_iw = (t >= 1 && t <= 8) ? 1 : ((t >= 17 && t <= 20) ? 2 : 0);
            check($sformatf("t2_rd[%0d]", t), rd_tr[t], e_rd);
            check($sformatf("t2_iw[%0d]", t), iw_tr[t], e_iw);
            check($sformatf("t2_done[%0d]", t), dn_tr[t], (t == 25) ? 1 : 0);
        end
        check("t2_busy_after_done", bz_tr[26], 0);
        check("t2_out_cnt", out_cnt, 4);
        $display("tile2 num_x=4 done_t=%0d k=%0d x=%0d out_cnt=%0d", done_t, n_k, n_x, out_cnt);

        // 3: L0 empty on KLOAD cycles 2-4
        run_tile(1, 2, 4, -1, -1, 24, 24, -1, -1);
        first_k = -1; last_k = -1; bubbles = 0;
        for (int t = 0; t <= last_t; t++) begin
            if (iw_tr[t] == 2'b01) begin
                if (first_k < 0) first_k = t;
                last_k = t;
            end
        end
        for (int t = first_k; t >= 0 && t <= last_k; t++)
            if (iw_tr[t] == 2'b00) bubbles++;
        check("t3_kload_count", n_k, 8);
        check("t3_bubbles", bubbles, 3);
        check("t3_done_t", done_t, 26);
        check("t3_done_count", n_done, 1);
        $display("tile3 num_x=1 done_t=%0d k=%0d bubbles=%0d", done_t, n_k, bubbles);

        // 4: OFIFO almost full for 5 EXEC cycles, extra valids after saturation
        run_tile(10, -1, -1, 18, 22, 32, 44, -1, -1);
        check("t4_rd_during_afull", rd_af, 0);
        check("t4_exec_count", n_x, 10);
        check("t4_done_t", done_t, 43);
        check("t4_out_cnt_sat", out_cnt, 10);
        $display("tile4 num_x=10 done_t=%0d x=%0d out_cnt=%0d", done_t, n_x, out_cnt);

        // 5: num_x=0 goes straight from KFLUSH to DONE
        run_tile(0, -1, -1, -1, -1, -1, -1, -1, -1);
        check("t5_kload_count", n_k, 8);
        check("t5_exec_count", n_x, 0);
        check("t5_done_t", done_t, 16);
        check("t5_done_count", n_done, 1);
        $display("tile5 num_x=0 done_t=%0d k=%0d x=%0d", done_t, n_k, n_x);

        // 6: reset in EXEC aborts the tile, then a clean tile with a stray start
        run_tile(4, -1, -1, -1, -1, -1, -1, -1, 17);
        check("t6_abort_busy_before", bz_tr[17], 1);
        for (int t = 18; t <= 21; t++) begin
            check($sformatf("t6_abort_busy[%0d]", t), bz_tr[t], 0);
            check($sformatf("t6_abort_iw[%0d]", t), iw_tr[t], 0);
        end
        check("t6_abort_done_count", n_done, 0);
        check("t6_abort_out_cnt", out_cnt, 0);
        $display("tile6a aborted done_count=%0d out_cnt=%0d", n_done, out_cnt);
        run_tile(2, -1, -1, -1, -1, 20, 21, 5, -1);
        check("t6_exec_count", n_x, 2);
        check("t6_done_t", done_t, 23);
        check("t6_out_cnt", out_cnt, 2);
        $display("tile6b num_x=2 done_t=%0d x=%0d out_cnt=%0d", done_t, n_x, out_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
